// File: rtl/sw_pkg.sv
// Shared constants for the switch-conditioning front end.
//   SW_WIDTH       : switch bank width
//   CLK_HZ         : system clock frequency
//   DEBOUNCE_MS    : debounce window in milliseconds
//   cycles_from_ms : converts a window in ms to clk cycles
package sw_pkg;

  localparam int unsigned SW_WIDTH    = 4;
  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  function automatic int unsigned cycles_from_ms(input int unsigned ms);
    return CLK_HZ / 1000 * ms;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser, stability counter and edge-pulse register.
// Build option: SW_DEBOUNCE_EDGE_EN enables the sw_rise/sw_fall registers;
// without it both pulses are tied to 0 and sw_clean is unchanged.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   sw       : raw switch bit, asynchronous to clk
//   sw_clean : debounced level
//   sw_rise  : one-cycle pulse when sw_clean goes 0->1
//   sw_fall  : one-cycle pulse when sw_clean goes 1->0
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   clean_d;

  // Metastability chain; s is the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Count consecutive cycles where s disagrees with sw_clean; any agreement
  // restarts the window, and the counter clears when the new level is taken.
  always_comb begin
    cnt_d   = '0;
    clean_d = sw_clean;
    if (s != sw_clean) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sw_clean <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sw_clean <= clean_d;
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Pulses are registered alongside sw_clean so they share its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= clean_d & ~sw_clean;
      sw_fall <= ~clean_d & sw_clean;
    end
  end
`else
  assign sw_rise = 1'b0;
  assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Switch-bank conditioning: per-bit synchronise, debounce and edge detect.
// Build option: SW_DEBOUNCE_EDGE_EN enables sw_rise/sw_fall (else tied to 0).
//   clk      : system clock, 100 MHz
//   rst_n    : asynchronous active-low reset
//   sw       : raw switch pins [WIDTH]
//   sw_clean : debounced levels [WIDTH]
//   sw_rise  : accepted 0->1 pulses [WIDTH]
//   sw_fall  : accepted 1->0 pulses [WIDTH]
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS),
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  // Each bit is debounced independently.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw      (sw[i]),
      .sw_clean(sw_clean[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a window model predicts each cycle's
// outputs, a monitor pops and compares on every falling edge.
module tb_sw_debounce;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;

  int total = 0;
  int bad   = 0;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   samp_q[$];
  logic [W-1:0]   m_clean = '0;

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  // Reference: at each edge a bit flips once the D synchronised samples
  // (sw seen SS..SS+D-1 edges ago) all disagree with the current level.
  always @(posedge clk) begin : model
    logic [W-1:0] nclean, rise, fall;
    logic         all_diff, sv;
    if (!rst_n) begin
      samp_q.delete();
      m_clean = '0;
      exp_q.push_back('0);
    end else begin
      nclean = m_clean;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int k = SS; k < SS + D; k++) begin
          sv = (k - 1 < samp_q.size()) ? samp_q[k-1][i] : 1'b0;
          if (sv == m_clean[i]) all_diff = 1'b0;
        end
        if (all_diff) nclean[i] = ~m_clean[i];
      end
      rise = nclean & ~m_clean;
      fall = ~nclean & m_clean;
`ifndef SW_DEBOUNCE_EDGE_EN
      rise = '0;
      fall = '0;
`endif
      m_clean = nclean;
      exp_q.push_back({m_clean, rise, fall});
      samp_q.push_front(sw);
      if (samp_q.size() > SS + D) void'(samp_q.pop_back());
    end
  end

  // Monitor: outputs are valid every cycle; compare away from the active edge.
  always @(negedge clk) begin : monitor
    logic [3*W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({sw_clean, sw_rise, sw_fall} !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=%b",
                 $time, sw_clean, sw_rise, sw_fall, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
      end
    end
  end

  task automatic drive(input logic [W-1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      sw = v;
    end
  endtask

  // Called right after rst_n release; the first edge takes the first sample.
  task automatic latency_check(input logic [W-1:0] want, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (sw_clean === want) seen = 1'b1;
    end
    total++;
    if (!seen || n - 1 != SS - 1 + D) begin
      bad++;
      $display("FAIL %s got %0d edges after first sample (seen=%0d) want %0d",
               name, n - 1, seen, SS - 1 + D);
    end
  endtask

  initial begin : stim
    logic [W-1:0] rv;
    // Reset with switches held high.
    rst_n = 1'b0;
    sw    = 4'b1111;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    latency_check(4'b1111, "reset_release_latency");
    drive(4'b1111, 5);

    // Clean steps.
    drive(4'b0000, 15);
    drive(4'b1010, 15);

    // Bounce on bit 0, then settle high.
    for (int c = 0; c < 40; c++) drive({3'b101, 1'((c / 3) % 2 == 0)}, 1);
    drive(4'b1011, 15);

    // Glitches on bit 2: 7 cycles rejected, 8 cycles accepted.
    drive(4'b1111, 7);
    drive(4'b1011, 15);
    drive(4'b1111, 8);
    drive(4'b1011, 20);

    // Simultaneous opposite changes.
    drive(4'b1010, 15);
    drive(4'b0101, 15);

    // Random levels with random hold times.
    for (int r = 0; r < 40; r++) begin
      rv = W'($urandom_range(0, 15));
      drive(rv, int'($urandom_range(1, 12)));
    end

    // Reset in the middle of a count, with sw_clean high beforehand.
    drive(4'b1111, 15);
    drive(4'b0101, 7);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sw_clean, sw_rise, sw_fall} !== '0) begin
      bad++;
      $display("FAIL async_reset got clean=%b rise=%b fall=%b want all 0",
               sw_clean, sw_rise, sw_fall);
    end
    sw = 4'b1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    latency_check(4'b1111, "requalify_latency");
    drive(4'b1111, 5);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL drain got %0d pending want <=1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
